display_scan_ctrl: RTL
======================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 100000, clk cycles per digit slot (legal range 4 or more).
REQ-002 SHALL provide parameter BLANK_CYCLES, default 16, anode-off guard cycles at the start of each slot (legal range 1 to REFRESH_DIV-1).
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port digits_in, input, 16, four BCD nibbles; [3:0] is digit 0 (rightmost).
REQ-006 SHALL have port dp_in, input, 4, decimal point per digit, active-high.
REQ-007 SHALL have port update_req, input, 1, single-cycle pulse requesting display of digits_in and dp_in.
REQ-008 SHALL have port blank_in, input, 1, level; forces all anodes off.
REQ-009 SHALL have port an, output, 4, active-low one-hot digit anode enables.
REQ-010 SHALL have port digit_sel, output, 4, BCD value presented to the segment decoder.
REQ-011 SHALL have port dp_n, output, 1, active-low decimal point.
REQ-012 SHALL have port update_ack, output, 1, one-cycle pulse when requested data becomes visible.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse at each completed 4-digit frame.

Function
REQ-014 Prescaler SHALL count 0 to REFRESH_DIV-1 and wrap; the wrap cycle is the slot tick.
REQ-015 Slot index SHALL advance 0→1→2→3→0 on each slot tick; frame_done SHALL pulse in the cycle after the 3→0 wrap.
REQ-016 Two-state FSM per slot: GUARD while prescaler < BLANK_CYCLES, then SHOW until the slot tick; GUARD→SHOW at prescaler == BLANK_CYCLES.
REQ-017 In GUARD, an SHALL be 4'b1111 and dp_n SHALL be 1.
REQ-018 In SHOW, an SHALL drive bit[index] low and all others high, digit_sel SHALL be shadow nibble[index], and dp_n SHALL be ~shadow_dp[index].
REQ-019 All outputs SHALL be registered, changing one cycle after the internal state that causes them.
REQ-020 On update_req, digits_in and dp_in SHALL be captured into a staging register and a pending flag set; a later update_req before transfer SHALL overwrite staging (last request wins).
REQ-021 At the next 3→0 frame boundary with pending set, staging SHALL copy to the shadow register, pending SHALL clear, and update_ack SHALL pulse in the same cycle as frame_done.
REQ-022 An update_req coinciding with the frame-boundary cycle SHALL be applied at that boundary, bypassing staging.
REQ-023 Shadow data SHALL never change mid-frame, so no torn display is possible.
REQ-024 blank_in high SHALL force an to 4'b1111 and dp_n to 1 within one cycle; prescaler, index, and update handling SHALL continue running.
REQ-025 Nibbles above 9 SHALL pass to digit_sel unmodified, and the decoder blanks them.

Reset
REQ-026 While reset is asserted, prescaler, index, staging, and shadow SHALL be 0; pending SHALL be 0; FSM SHALL be in GUARD; an SHALL be 4'b1111; digit_sel SHALL be 0; dp_n SHALL be 1; update_ack and frame_done SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL discard pending updates, and display after release SHALL start at slot 0 in GUARD.

Configuration
REQ-028 With macro LEADING_ZERO_BLANK_EN defined, digits 3..1 whose shadow value is 0 and all of whose higher digits are 0 SHALL keep their anode off during SHOW; digit 0 is always shown. dp_n still follows shadow_dp for a blanked digit.
REQ-029 With LEADING_ZERO_BLANK_EN undefined, all four digits SHALL be shown in SHOW.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-030 Reset release, then 32 cycles. Required: an sequence per slot is 1111,1111 followed by 1110×6, then 1101, 1011, 0111; frame_done pulses once.
REQ-031 update_req with digits_in=16'h1234 mid-frame. Required: digit_sel stays 0 until the boundary, update_ack coincides with frame_done, and the next frame shows 4,3,2,1.
REQ-032 Two update_req pulses (16'h1111 then 16'h5678) in one frame. Required: only 5678 is displayed, with a single update_ack.
REQ-033 update_req with 16'h0042 on the boundary cycle. Required: shown immediately. With LEADING_ZERO_BLANK_EN, slots 3 and 2 have an=1111 in SHOW. Without it, slots 3 and 2 show 0.
REQ-034 blank_in high for 10 cycles. Required: an=1111 throughout, frame timing unchanged; reset pulse mid-slot returns all outputs to reset values and clears pending.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed 4-digit display scanner.
//
// A prescaler divides clk into REFRESH_DIV-cycle digit slots. Each slot opens
// with BLANK_CYCLES of anode-off guard time (GUARD), then drives its digit
// (SHOW). New digits are staged on update_req and moved into the shadow
// register only at the 3->0 frame boundary, so a frame never mixes old and new
// data. Every output is registered one cycle behind the state that causes it.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to keep the anodes of leading
// zero digits (3..1) off during SHOW. Digit 0 is always shown.
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        update_req,
  input  logic        blank_in,
  output logic [3:0]  an,
  output logic [3:0]  digit_sel,
  output logic        dp_n,
  output logic        update_ack,
  output logic        frame_done
);

  localparam int            PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_END  = PW'(BLANK_CYCLES);

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic [1:0]    idx;
  logic          slot_tick;
  logic          frame_wrap;

  logic [15:0]   staging;
  logic [3:0]    staging_dp;
  logic [15:0]   shadow;
  logic [3:0]    shadow_dp;
  logic          pending;

  logic [3:0]    digit_en;
  logic [3:0]    an_next;
  logic [3:0]    digit_next;
  logic          dp_n_next;

  // The last prescaler count is the slot tick; the tick in slot 3 closes a frame.
  assign slot_tick  = (presc == PRESC_LAST);
  assign frame_wrap = slot_tick && (idx == 2'd3);
  assign presc_next = slot_tick ? '0 : presc + PW'(1);

  // Prescaler and slot index: free-running, unaffected by blank_in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= 2'd0;
    end else begin
      presc <= presc_next;
      if (slot_tick) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= GUARD;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: GUARD holds while the prescaler is below BLANK_CYCLES,
  // SHOW holds until the slot tick returns the prescaler to 0.
  always_comb begin
    state_next = state;
    case (state)
      GUARD: begin
        if (presc_next == GUARD_END) begin
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (slot_tick) begin
          state_next = GUARD;
        end
      end
      default: state_next = GUARD;
    endcase
  end

  // Update handshake: requests land in staging until the frame boundary, where
  // staging (or a request arriving on that very cycle) moves into the shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging    <= 16'h0000;
      staging_dp <= 4'h0;
      shadow     <= 16'h0000;
      shadow_dp  <= 4'h0;
      pending    <= 1'b0;
      update_ack <= 1'b0;
    end else begin
      update_ack <= 1'b0;
      if (frame_wrap && (update_req || pending)) begin
        shadow     <= update_req ? digits_in : staging;
        shadow_dp  <= update_req ? dp_in     : staging_dp;
        pending    <= 1'b0;
        update_ack <= 1'b1;
      end else if (update_req) begin
        staging    <= digits_in;
        staging_dp <= dp_in;
        pending    <= 1'b1;
      end
    end
  end

  // Frame-done pulse lands in the first cycle of the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Leading-zero mask: a digit stays lit once it or any higher digit is nonzero.
  always_comb begin
    digit_en    = 4'b1111;
    digit_en[3] = (shadow[15:12] != 4'd0);
    digit_en[2] = digit_en[3] || (shadow[11:8] != 4'd0);
    digit_en[1] = digit_en[2] || (shadow[7:4]  != 4'd0);
    digit_en[0] = 1'b1;
  end
`else
  assign digit_en = 4'b1111;
`endif

  // Output decode from the current state; nibbles above 9 pass through as-is.
  always_comb begin
    an_next    = 4'b1111;
    dp_n_next  = 1'b1;
    digit_next = shadow[{idx, 2'b00} +: 4];
    if ((state == SHOW) && !blank_in) begin
      if (digit_en[idx]) begin
        an_next[idx] = 1'b0;
      end
      dp_n_next = ~shadow_dp[idx];
    end
  end

  // Output register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an        <= 4'b1111;
      digit_sel <= 4'h0;
      dp_n      <= 1'b1;
    end else begin
      an        <= an_next;
      digit_sel <= digit_next;
      dp_n      <= dp_n_next;
    end
  end

endmodule
